pdm_mic_receiver: RTL and testbench
===================================

Name: pdm_mic_receiver

Overview:
Receive side of the board audio path. Drives the on-board PDM microphone clock, samples its 1-bit stream, and decimates it with a boxcar ones-counter into signed PCM samples. A loudness detector with a small state machine turns sustained loud input (clap or shout) into a `jump` level that feeds the game logic and `audio_engine`.

Parameters:
CLK_DIV, 25, `M_CLK` half-period in `CLK100MHZ` cycles (default gives 2 MHz mic clock).
DECIM, 64, PDM bits per PCM sample (default gives 31.25 kHz sample rate).
THRESH, 24, loudness magnitude threshold; a sample is loud when level >= THRESH.
LOUD_RUN, 4, consecutive loud samples needed to trigger.
HOLD_SAMPLES, 8192, samples for which `jump` stays high after a trigger.
COOLDOWN_SAMPLES, 4096, samples after hold during which loudness is ignored.

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous active-low reset
mic_en  in  1  enable; low stops the mic clock and clears the datapath
M_DATA  in  1  PDM data from mic (asynchronous)
M_CLK  out  1  PDM clock to mic
M_LRSEL  out  1  channel select, constant 0 (data valid after `M_CLK` rising edge)
pcm_sample  out  CW+1  signed PCM sample, CW = $clog2(DECIM+1)
pcm_valid  out  1  one-cycle strobe when `pcm_sample` updates
level  out  CW  |pcm_sample|, updates with `pcm_valid`
jump  out  1  registered trigger level

Behaviour:
- Clock and reset: one clock, `CLK100MHZ`; reset `CPU_RESETN` is asynchronous and active-low.
- Reset values: `M_CLK`=0, `pcm_sample`=0, `pcm_valid`=0, `level`=0, `jump`=0, FSM=IDLE, all counters 0. `M_LRSEL` is tied 0 at all times.
- Clock divider:
  - Counter runs 0..CLK_DIV-1; `M_CLK` toggles on wrap.
  - Period is 2*CLK_DIV cycles with 50% duty.
  - `M_CLK` starts high CLK_DIV cycles after `mic_en` rises.
- Input path:
  - `M_DATA` passes through a 2-flop synchronizer.
  - A bit is captured on the cycle `M_CLK` is driven from 1 to 0 (the falling event), using the synchronized value.
- Decimator:
  - `ones` counter (CW bits) counts captured 1s; `bitcnt` counts captured bits.
  - On the DECIM-th bit: `pcm_sample` = 2*ones_total - DECIM (signed, range -DECIM..+DECIM), where ones_total includes the current bit.
  - On the same edge, `level` = |that value|, `pcm_valid`=1 for exactly one cycle, and `ones`/`bitcnt` restart at 0 with the current bit already counted.
  - No capture is lost at window boundaries.
- Loudness FSM, evaluated only on `pcm_valid` cycles (uses the new `level`):
  - IDLE: a loud sample increments `run`; a quiet sample clears `run`. When `run` reaches LOUD_RUN, go to TRIGGER, set `jump`=1 on that same edge, load `tmr`=HOLD_SAMPLES-1, clear `run`.
  - TRIGGER: `jump`=1; each sample decrements `tmr`. At `tmr`=0 go to COOLDOWN, `jump`=0, load `tmr`=COOLDOWN_SAMPLES-1.
  - COOLDOWN: loud samples are ignored and `run` stays 0. At `tmr`=0 go to IDLE.
- `mic_en` low (synchronous, next edge):
  - `M_CLK`=0 and divider cleared.
  - Partial window discarded (`ones`/`bitcnt` 0), no `pcm_valid`.
  - FSM=IDLE, `jump`=0, `run`/`tmr` 0.
  - `pcm_sample`/`level` hold their last values.
- Reset asserted mid-operation clears everything immediately, including during TRIGGER.
- Timer is 16 bits wide; parameters must satisfy HOLD_SAMPLES, COOLDOWN_SAMPLES <= 65536 and LOUD_RUN >= 1.

Decomposition:
- Shared package `audio_pkg`:
  - FSM state typedef {IDLE, TRIGGER, COOLDOWN}.
  - Constants for the default mic clock divider and decimation factor.
  - CW derivation function.
- Sub-module `pdm_clkgen`: divider, `M_CLK`, and a one-cycle capture strobe. Decimator and FSM stay in the top.

Test Plan:
1. Hold `CPU_RESETN`=0 with `mic_en`=1 and toggling `M_DATA` -> `M_CLK`=0, `jump`=0, `pcm_valid`=0, `pcm_sample`=0. Release reset -> first `M_CLK` rise 25 cycles after; period measured at 50 cycles with 25 high.
2. `M_DATA`=1 constant -> `pcm_sample`=+64, `level`=64, `pcm_valid` pulses exactly once per 3200 cycles. `M_DATA`=0 -> `pcm_sample`=-64.
3. `M_DATA` alternating 1/0 on successive `M_CLK` periods -> `pcm_sample`=0, `level`=0; run 100 samples -> `jump` never asserts.
4. Apply 3 loud windows then 1 quiet, repeat -> no trigger. Apply 4 consecutive all-ones windows -> `jump` rises on the edge of the 4th `pcm_valid` and stays high 8192 samples. Then 4096 samples of loud input -> `jump` stays 0. Then 4 more loud samples -> `jump` rises again.
5. Drop `mic_en` 1000 cycles into a window -> `M_CLK` low next cycle, no `pcm_valid`. Re-enable with `M_DATA`=1 -> first sample exactly +64 (partial window discarded).
6. Assert `CPU_RESETN` low for 1 cycle during TRIGGER -> `jump`=0 asynchronously. After release, FSM is in IDLE and needs 4 fresh loud samples to re-trigger.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the board audio receive path.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRIGGER,
        COOLDOWN
    } fsm_state_t;

    localparam int unsigned DEF_CLK_DIV = 25;
    localparam int unsigned DEF_DECIM   = 64;

    // Counter width able to hold 0..decim inclusive.
    function automatic int unsigned calc_cw(input int unsigned decim);
        return $clog2(decim + 1);
    endfunction

endpackage

// File: rtl/pdm_clkgen.sv
// PDM microphone clock divider with a one-cycle capture strobe.
module pdm_clkgen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic CLK100MHZ,
    input  logic CPU_RESETN,
    input  logic en,
    output logic m_clk,
    output logic cap
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt   <= '0;
            m_clk <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            m_clk <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            m_clk <= ~m_clk;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // High during the cycle whose closing edge drives m_clk from 1 to 0.
    assign cap = en && wrap && m_clk;

endmodule

// File: rtl/pdm_mic_receiver.sv
// PDM microphone receiver: boxcar decimation to signed PCM plus a
// loudness detector that raises a held `jump` level on sustained loud input.
module pdm_mic_receiver
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV          = DEF_CLK_DIV,
    parameter int unsigned DECIM            = DEF_DECIM,
    parameter int unsigned THRESH           = 24,
    parameter int unsigned LOUD_RUN         = 4,
    parameter int unsigned HOLD_SAMPLES     = 8192,
    parameter int unsigned COOLDOWN_SAMPLES = 4096,
    localparam int unsigned CW              = calc_cw(DECIM)
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    input  logic                 mic_en,
    input  logic                 M_DATA,
    output logic                 M_CLK,
    output logic                 M_LRSEL,
    output logic signed [CW:0]   pcm_sample,
    output logic                 pcm_valid,
    output logic [CW-1:0]        level,
    output logic                 jump
);

    localparam int unsigned RW = $clog2(LOUD_RUN + 1);

    logic          cap;
    logic          sync1, sync2;
    logic [CW-1:0] ones, bitcnt, ones_total;
    logic [CW:0]   dbl, mag;
    logic          neg, win_end, loud;
    logic [CW:0]   pcm_next;

    fsm_state_t    state;
    logic [RW-1:0] run;
    logic [15:0]   tmr;

    assign M_LRSEL = 1'b0;

    pdm_clkgen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkgen (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .en        (mic_en),
        .m_clk     (M_CLK),
        .cap       (cap)
    );

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= M_DATA;
            sync2 <= sync1;
        end
    end

    // Window result is formed from the count including the bit captured now,
    // so the sample, level and FSM step all land on the same edge.
    always_comb begin
        win_end    = cap && (bitcnt == CW'(DECIM - 1));
        ones_total = ones + CW'(sync2);
        dbl        = {ones_total, 1'b0};
        neg        = (dbl < (CW + 1)'(DECIM));
        mag        = neg ? ((CW + 1)'(DECIM) - dbl) : (dbl - (CW + 1)'(DECIM));
        pcm_next   = neg ? (~mag + 1'b1) : mag;
        loud       = (32'(mag) >= THRESH);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            ones       <= '0;
            bitcnt     <= '0;
            pcm_sample <= '0;
            level      <= '0;
            pcm_valid  <= 1'b0;
            state      <= IDLE;
            run        <= '0;
            tmr        <= '0;
            jump       <= 1'b0;
        end else if (!mic_en) begin
            ones      <= '0;
            bitcnt    <= '0;
            pcm_valid <= 1'b0;
            state     <= IDLE;
            run       <= '0;
            tmr       <= '0;
            jump      <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (win_end) begin
                ones       <= '0;
                bitcnt     <= '0;
                pcm_sample <= $signed(pcm_next);
                level      <= mag[CW-1:0];
                pcm_valid  <= 1'b1;
                case (state)
                    IDLE: begin
                        if (!loud) begin
                            run <= '0;
                        end else if (run == RW'(LOUD_RUN - 1)) begin
                            state <= TRIGGER;
                            jump  <= 1'b1;
                            tmr   <= 16'(HOLD_SAMPLES - 1);
                            run   <= '0;
                        end else begin
                            run <= run + 1'b1;
                        end
                    end
                    TRIGGER: begin
                        if (tmr == '0) begin
                            state <= COOLDOWN;
                            jump  <= 1'b0;
                            tmr   <= 16'(COOLDOWN_SAMPLES - 1);
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    COOLDOWN: begin
                        run <= '0;
                        if (tmr == '0) begin
                            state <= IDLE;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        jump  <= 1'b0;
                        run   <= '0;
                        tmr   <= '0;
                    end
                endcase
            end else if (cap) begin
                ones   <= ones_total;
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// Self-checking bench for pdm_mic_receiver using scaled-down parameters.
module tb_pdm_mic_receiver;

    localparam int CLK_DIV  = 4;
    localparam int DECIM    = 8;
    localparam int THRESH   = 4;
    localparam int LOUD_RUN = 4;
    localparam int HOLD     = 16;
    localparam int COOL     = 8;
    localparam int CW       = $clog2(DECIM + 1);
    localparam int WIN_CYC  = 2 * CLK_DIV * DECIM;

    logic                CLK100MHZ  = 1'b0;
    logic                CPU_RESETN = 1'b0;
    logic                mic_en     = 1'b0;
    logic                M_DATA     = 1'b0;
    logic                M_CLK, M_LRSEL, pcm_valid, jump;
    logic signed [CW:0]  pcm_sample;
    logic [CW-1:0]       level;

    always #5 CLK100MHZ = ~CLK100MHZ;

    pdm_mic_receiver #(
        .CLK_DIV         (CLK_DIV),
        .DECIM           (DECIM),
        .THRESH          (THRESH),
        .LOUD_RUN        (LOUD_RUN),
        .HOLD_SAMPLES    (HOLD),
        .COOLDOWN_SAMPLES(COOL)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .CPU_RESETN(CPU_RESETN),
        .mic_en    (mic_en),
        .M_DATA    (M_DATA),
        .M_CLK     (M_CLK),
        .M_LRSEL   (M_LRSEL),
        .pcm_sample(pcm_sample),
        .pcm_valid (pcm_valid),
        .level     (level),
        .jump      (jump)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: bit stream queue, expected samples, and a jump
    // predictor expressed as "samples elapsed since the last trigger".
    bit bitq[$];
    int exp_pcm_q[$];
    bit exp_jump_q[$];
    int m_since = -1;
    int m_run   = 0;

    task automatic model_reset();
        m_since = -1;
        m_run   = 0;
    endtask

    function automatic bit model_step(input bit is_loud);
        if (m_since >= 0) begin
            m_since++;
            if (m_since <= HOLD + COOL) return (m_since < HOLD);
            m_since = -1;
        end
        m_run = is_loud ? m_run + 1 : 0;
        if (m_run == LOUD_RUN) begin
            m_run   = 0;
            m_since = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push_window(input logic [DECIM-1:0] bits, input int pcm);
        for (int i = 0; i < DECIM; i++) bitq.push_back(bits[i]);
        exp_pcm_q.push_back(pcm);
        exp_jump_q.push_back(model_step(((pcm < 0) ? -pcm : pcm) >= THRESH));
    endtask

    // Mic model: presents the next bit just after each M_CLK rising edge.
    bit drv_toggle = 1'b0;
    bit prev_mclk  = 1'b0;
    always begin
        @(posedge CLK100MHZ);
        #1;
        if (drv_toggle) M_DATA = ~M_DATA;
        else if (M_CLK && !prev_mclk) M_DATA = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
        prev_mclk = M_CLK;
    end

    int cyc = 0;
    int vcount = 0;
    int valid_cycles[$];
    bit prev_valid = 1'b0;
    bit jump_seen  = 1'b0;
    int mon_p;
    bit mon_j;
    always begin
        @(posedge CLK100MHZ);
        #1;
        cyc++;
        if (jump === 1'b1) jump_seen = 1'b1;
        if (pcm_valid === 1'b1) begin
            vcount++;
            valid_cycles.push_back(cyc);
            check("valid_one_cycle", int'(prev_valid), 0);
            if (exp_pcm_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pcm %0d expected no sample", int'(pcm_sample));
            end else begin
                mon_p = exp_pcm_q.pop_front();
                mon_j = exp_jump_q.pop_front();
                check("pcm_sample", int'(pcm_sample), mon_p);
                check("level", int'(level), (mon_p < 0) ? -mon_p : mon_p);
                check("jump", int'(jump), int'(mon_j));
            end
        end
        prev_valid = pcm_valid;
    end

    task automatic wait_drain();
        int n;
        int budget;
        n = 0;
        budget = (exp_pcm_q.size() + 2) * WIN_CYC + 4 * CLK_DIV;
        while (exp_pcm_q.size() > 0 && n < budget) begin
            @(posedge CLK100MHZ);
            n++;
        end
        check("drain_remaining", exp_pcm_q.size(), 0);
        exp_pcm_q.delete();
        exp_jump_q.delete();
    endtask

    task automatic start_group();
        @(negedge CLK100MHZ);
        mic_en = 1'b1;
    endtask

    task automatic end_group();
        @(negedge CLK100MHZ);
        mic_en = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        bitq.delete();
        model_reset();
    endtask

    typedef struct {
        logic [DECIM-1:0] bits;
        int               pcm;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, lo, k, p;
        logic [DECIM-1:0] rb;

        vt[0] = '{8'hFF,  8};
        vt[1] = '{8'h00, -8};
        vt[2] = '{8'hAA,  0};
        vt[3] = '{8'h01, -6};
        vt[4] = '{8'hFE,  6};
        vt[5] = '{8'h0F,  0};
        vt[6] = '{8'h3F,  4};
        vt[7] = '{8'h07, -2};

        // Reset held while enabled and data toggling; then clock timing.
        mic_en     = 1'b1;
        drv_toggle = 1'b1;
        repeat (10) @(negedge CLK100MHZ);
        check("rst_mclk", int'(M_CLK), 0);
        check("rst_jump", int'(jump), 0);
        check("rst_valid", int'(pcm_valid), 0);
        check("rst_pcm", int'(pcm_sample), 0);
        check("rst_level", int'(level), 0);
        check("lrsel", int'(M_LRSEL), 0);
        drv_toggle = 1'b0;
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        n = 0;
        while (M_CLK !== 1'b1 && n < 100) begin
            @(posedge CLK100MHZ); #1; n++;
        end
        check("first_mclk_rise", n, CLK_DIV);
        hi = 0;
        while (M_CLK === 1'b1 && hi < 100) begin
            @(posedge CLK100MHZ); #1; hi++;
        end
        lo = 0;
        while (M_CLK === 1'b0 && lo < 100) begin
            @(posedge CLK100MHZ); #1; lo++;
        end
        check("mclk_high", hi, CLK_DIV);
        check("mclk_period", hi + lo, 2 * CLK_DIV);
        end_group();

        // Constant ones: +DECIM each window at a fixed rate.
        for (int i = 0; i < 4; i++) push_window(8'hFF, DECIM);
        valid_cycles.delete();
        start_group();
        wait_drain();
        check("valid_count", valid_cycles.size(), 4);
        for (int i = 1; i < valid_cycles.size(); i++)
            check("valid_interval", valid_cycles[i] - valid_cycles[i-1], WIN_CYC);
        end_group();

        for (int i = 0; i < 2; i++) push_window(8'h00, -DECIM);
        start_group();
        wait_drain();
        end_group();

        // Vector table.
        for (int i = 0; i < 8; i++) push_window(vt[i].bits, vt[i].pcm);
        start_group();
        wait_drain();
        end_group();

        // Alternating bits: silence, never triggers.
        for (int i = 0; i < 100; i++) push_window(8'hAA, 0);
        jump_seen = 1'b0;
        start_group();
        wait_drain();
        check("jump_never_alt", int'(jump_seen), 0);
        end_group();

        // Broken runs, trigger, hold, cooldown, retrigger.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) push_window(8'hFF, DECIM);
            push_window(8'h0F, 0);
        end
        for (int i = 0; i < 4 + HOLD + COOL + 4; i++) push_window(8'hFF, DECIM);
        start_group();
        wait_drain();
        check("jump_after_retrigger", int'(jump), 1);
        end_group();

        // Disable mid-window while M_CLK is high; partial window discarded.
        push_window(8'hFF, DECIM);
        for (int i = 0; i < DECIM; i++) bitq.push_back(1'b0);
        start_group();
        wait_drain();
        repeat (3 * 2 * CLK_DIV) @(posedge CLK100MHZ);
        n = 0;
        while (M_CLK !== 1'b1 && n < 100) begin
            @(posedge CLK100MHZ); #1; n++;
        end
        @(negedge CLK100MHZ);
        mic_en = 1'b0;
        n = vcount;
        @(posedge CLK100MHZ); #1;
        check("mclk_off", int'(M_CLK), 0);
        repeat (200) @(posedge CLK100MHZ);
        check("no_valid_disabled", vcount, n);
        check("pcm_hold", int'(pcm_sample), DECIM);
        check("level_hold", int'(level), DECIM);
        bitq.delete();
        model_reset();
        push_window(8'hFF, DECIM);
        start_group();
        wait_drain();
        end_group();

        // Asynchronous reset during TRIGGER; re-trigger needs a fresh run.
        for (int i = 0; i < 10; i++) push_window(8'hFF, DECIM);
        start_group();
        n = 0;
        while (jump !== 1'b1 && n < 10 * WIN_CYC) begin
            @(posedge CLK100MHZ); #1; n++;
        end
        check("jump_before_reset", int'(jump), 1);
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b0;
        #1;
        check("jump_async_clear", int'(jump), 0);
        check("mclk_async_clear", int'(M_CLK), 0);
        exp_pcm_q.delete();
        exp_jump_q.delete();
        bitq.delete();
        model_reset();
        for (int i = 0; i < 4; i++) push_window(8'hFF, DECIM);
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        wait_drain();
        check("jump_retrigger_after_reset", int'(jump), 1);
        end_group();

        // Randomized windows against the model.
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, DECIM);
            for (int b = 0; b < DECIM; b++) rb[b] = ($urandom_range(0, DECIM - 1) < k);
            p = 2 * $countones(rb) - DECIM;
            push_window(rb, p);
        end
        start_group();
        wait_drain();
        end_group();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
